txtlcd_textbuf: RTL and testbench

TXTLCD_TEXTBUF -- requirements
Module: txtlcd_textbuf

---
 rtl/txtlcd_pkg.sv | 15 +
 rtl/txtlcd_ram.sv | 40 ++++
 rtl/txtlcd_textbuf.sv | 147 ++++++++++++++
 tb/tb_txtlcd_textbuf.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/txtlcd_pkg.sv
// Shared definitions for the text-LCD character buffer.
// Holds the buffer FSM state type and the control/fill character codes.
package txtlcd_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  localparam logic [7:0] CHR_LF    = 8'h0A;
  localparam logic [7:0] CHR_FF    = 8'h0C;
  localparam logic [7:0] CHR_CR    = 8'h0D;
  localparam logic [7:0] CHR_SPACE = 8'h20;

endpackage

// File: rtl/txtlcd_ram.sv
// Character cell memory: DEPTH x 8, one synchronous write port and one
// asynchronous read port. Reads beyond DEPTH return a space. A read of the
// address being written returns the old content until the clock edge.
// Ports:
//   clk   - write clock (rising edge)
//   we    - write enable
//   waddr - write address
//   wdata - write data
//   raddr - read address
//   rdata - read data (combinational)
module txtlcd_ram
  import txtlcd_pkg::*;
#(
  parameter int DEPTH     = 80,
  parameter int ADDR_BITS = 7
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] waddr,
  input  logic [7:0]           wdata,
  input  logic [ADDR_BITS-1:0] raddr,
  output logic [7:0]           rdata
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata = CHR_SPACE;
    if (int'(raddr) < DEPTH) begin
      rdata = mem[raddr];
    end
  end

endmodule

// File: rtl/txtlcd_textbuf.sv
// Text buffer between a character producer and a text LCD controller.
// Printable codes are written at the cursor, LF/CR move the cursor, FF
// sweeps the whole buffer to spaces. The LCD controller reads cells
// combinationally and gets a one-cycle update pulse after each change.
// Ports:
//   in_clk         - clock (rising edge)
//   in_rst         - asynchronous active-high reset
//   in_char        - character / control code
//   in_char_valid  - in_char is valid
//   out_char_ready - character accepted this cycle (IDLE only)
//   in_mem_addr    - controller read address
//   out_mem_word   - character at in_mem_addr
//   out_update     - one-cycle refresh request
//   out_cursor     - current write address
module txtlcd_textbuf
  import txtlcd_pkg::*;
#(
  parameter int LCD_SIZE  = 80,
  parameter int LCD_COLS  = 20,
  parameter int ADDR_BITS = 7
) (
  input  logic                 in_clk,
  input  logic                 in_rst,
  input  logic [7:0]           in_char,
  input  logic                 in_char_valid,
  output logic                 out_char_ready,
  input  logic [ADDR_BITS-1:0] in_mem_addr,
  output logic [7:0]           out_mem_word,
  output logic                 out_update,
  output logic [ADDR_BITS-1:0] out_cursor
);

  localparam int LCD_ROWS = LCD_SIZE / LCD_COLS;

  state_t                 state_q, state_d;
  logic [ADDR_BITS-1:0]   clr_addr_q;
  logic [ADDR_BITS-1:0]   row_q, col_q;
  logic [ADDR_BITS-1:0]   row_next;
  logic [ADDR_BITS-1:0]   cursor;
  logic                   update_q;
  logic                   clr_last;
  logic                   accept;
  logic                   we;
  logic [ADDR_BITS-1:0]   waddr;
  logic [7:0]             wdata;

  // Cursor is kept as row/column so LF/CR never need a divide.
  assign cursor   = ADDR_BITS'(int'(row_q) * LCD_COLS + int'(col_q));
  assign row_next = (row_q == ADDR_BITS'(LCD_ROWS - 1)) ? '0 : row_q + 1'b1;
  assign clr_last = (clr_addr_q == ADDR_BITS'(LCD_SIZE - 1));

  assign out_char_ready = (state_q == ST_IDLE);
  assign out_update     = update_q;
  assign out_cursor     = cursor;

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    we      = 1'b0;
    waddr   = clr_addr_q;
    wdata   = CHR_SPACE;
    case (state_q)
      ST_CLEAR: begin
        we = 1'b1;
        if (clr_last) begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        accept = in_char_valid;
        if (accept) begin
          case (in_char)
            CHR_FF:         state_d = ST_CLEAR;
            CHR_LF, CHR_CR: ;
            default: begin
              we    = 1'b1;
              waddr = cursor;
              wdata = in_char;
            end
          endcase
        end
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      state_q    <= ST_CLEAR;
      clr_addr_q <= '0;
      row_q      <= '0;
      col_q      <= '0;
      update_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      update_q <= 1'b0;
      if (state_q == ST_CLEAR) begin
        if (clr_last) begin
          clr_addr_q <= '0;
          update_q   <= 1'b1;
        end else begin
          clr_addr_q <= clr_addr_q + 1'b1;
        end
      end
      if (accept) begin
        case (in_char)
          CHR_FF: begin
            clr_addr_q <= '0;
            row_q      <= '0;
            col_q      <= '0;
          end
          CHR_LF: begin
            col_q    <= '0;
            row_q    <= row_next;
            update_q <= 1'b1;
          end
          CHR_CR: begin
            col_q    <= '0;
            update_q <= 1'b1;
          end
          default: begin
            if (col_q == ADDR_BITS'(LCD_COLS - 1)) begin
              col_q <= '0;
              row_q <= row_next;
            end else begin
              col_q <= col_q + 1'b1;
            end
            update_q <= 1'b1;
          end
        endcase
      end
    end
  end

  txtlcd_ram #(
    .DEPTH    (LCD_SIZE),
    .ADDR_BITS(ADDR_BITS)
  ) u_ram (
    .clk  (in_clk),
    .we   (we),
    .waddr(waddr),
    .wdata(wdata),
    .raddr(in_mem_addr),
    .rdata(out_mem_word)
  );

endmodule

// File: tb/tb_txtlcd_textbuf.sv
module tb_txtlcd_textbuf;

  localparam int LCD_SIZE  = 80;
  localparam int LCD_COLS  = 20;
  localparam int ADDR_BITS = 7;
  localparam int LCD_ROWS  = 4;
  localparam int WAIT_MAX  = 300;

  logic                 in_clk = 1'b0;
  logic                 in_rst = 1'b1;
  logic [7:0]           in_char = '0;
  logic                 in_char_valid = 1'b0;
  logic                 out_char_ready;
  logic [ADDR_BITS-1:0] in_mem_addr = '0;
  logic [7:0]           out_mem_word;
  logic                 out_update;
  logic [ADDR_BITS-1:0] out_cursor;

  txtlcd_textbuf #(
    .LCD_SIZE (LCD_SIZE),
    .LCD_COLS (LCD_COLS),
    .ADDR_BITS(ADDR_BITS)
  ) dut (
    .in_clk        (in_clk),
    .in_rst        (in_rst),
    .in_char       (in_char),
    .in_char_valid (in_char_valid),
    .out_char_ready(out_char_ready),
    .in_mem_addr   (in_mem_addr),
    .out_mem_word  (out_mem_word),
    .out_update    (out_update),
    .out_cursor    (out_cursor)
  );

  always #5 in_clk = ~in_clk;

  int n_cmp = 0;
  int n_err = 0;
  int cycles = 0;
  int updates_seen = 0;

  logic [7:0] mem_m [LCD_SIZE];
  logic [7:0] snap  [LCD_SIZE];
  int         cur_m = 0;
  int         sb_q[$];

  typedef struct {
    logic [7:0] ch;
    int         reps;
    int         exp_cur;
  } vec_t;
  vec_t tbl [14];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(posedge in_clk) cycles++;

  // Scoreboard: each accepted command (and each completed clear) pushes the
  // cursor expected while its update pulse is high.
  always @(negedge in_clk) begin
    if (!in_rst && out_update) begin
      updates_seen++;
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL sb_unexpected_update: got pulse with cursor %0d, expected none", out_cursor);
      end else begin
        check("sb_cursor", int'(out_cursor), sb_q.pop_front());
      end
    end
  end

  task automatic model_clear();
    for (int unsigned i = 0; i < LCD_SIZE; i++) mem_m[i] = 8'h20;
    cur_m = 0;
  endtask

  task automatic model_apply(input logic [7:0] c);
    case (c)
      8'h0A: cur_m = ((cur_m / LCD_COLS + 1) % LCD_ROWS) * LCD_COLS;
      8'h0D: cur_m = (cur_m / LCD_COLS) * LCD_COLS;
      8'h0C: model_clear();
      default: begin
        mem_m[cur_m] = c;
        cur_m = (cur_m + 1) % LCD_SIZE;
      end
    endcase
    sb_q.push_back(cur_m);
  endtask

  // Called at #1 after an edge; leaves in_char_valid high so consecutive
  // calls stream one character per cycle.
  task automatic send_char(input logic [7:0] c);
    int n;
    in_char = c;
    in_char_valid = 1'b1;
    n = 0;
    while (!out_char_ready && n < WAIT_MAX) begin
      @(posedge in_clk);
      #1;
      n++;
    end
    if (n >= WAIT_MAX) begin
      n_cmp++;
      n_err++;
      $display("FAIL ready_timeout: ready still low after %0d cycles, expected high", n);
    end
    in_mem_addr = ADDR_BITS'(cur_m);
    #1;
    check($sformatf("rd_before_wr[%0d]", cur_m), int'(out_mem_word), int'(mem_m[cur_m]));
    @(posedge in_clk);
    model_apply(c);
    #1;
  endtask

  task automatic idle(input int n);
    in_char_valid = 1'b0;
    repeat (n) @(posedge in_clk);
    #1;
  endtask

  task automatic sweep(input string tag);
    for (int unsigned a = 0; a < LCD_SIZE; a++) begin
      in_mem_addr = ADDR_BITS'(a);
      #1;
      check($sformatf("%s_mem[%0d]", tag, a), int'(out_mem_word), int'(mem_m[a]));
    end
  endtask

  task automatic read_at(input string name, input int addr, input int exp);
    in_mem_addr = ADDR_BITS'(addr);
    #1;
    check(name, int'(out_mem_word), exp);
  endtask

  // Counts sampled cycles with ready low; optionally probes one cell at
  // sample number probe_n to observe the clear in progress.
  task automatic count_low(input int probe_n, input int probe_addr, input int probe_exp,
                           output int n);
    n = 0;
    while (!out_char_ready && n < WAIT_MAX) begin
      n++;
      if (n == probe_n) begin
        in_mem_addr = ADDR_BITS'(probe_addr);
        #1;
        check("mid_clear_read", int'(out_mem_word), probe_exp);
        @(posedge in_clk);
        #1;
      end else begin
        @(posedge in_clk);
        #1;
      end
    end
  endtask

  initial begin
    int n;
    int u0;
    int c0;

    tbl[0]  = '{8'h63, 3, 5};
    tbl[1]  = '{8'h0A, 1, 20};
    tbl[2]  = '{8'h68, 7, 27};
    tbl[3]  = '{8'h0D, 1, 20};
    tbl[4]  = '{8'h0A, 1, 40};
    tbl[5]  = '{8'h0A, 1, 60};
    tbl[6]  = '{8'h6B, 7, 67};
    tbl[7]  = '{8'h0A, 1, 0};
    tbl[8]  = '{8'h0D, 1, 0};
    tbl[9]  = '{8'h6D, 19, 19};
    tbl[10] = '{8'h6E, 1, 20};
    tbl[11] = '{8'h0A, 1, 40};
    tbl[12] = '{8'h0A, 1, 60};
    tbl[13] = '{8'h0A, 1, 0};

    // Reset state and power-up clear
    model_clear();
    repeat (3) @(posedge in_clk);
    #1;
    check("rst_ready", int'(out_char_ready), 0);
    check("rst_update", int'(out_update), 0);
    check("rst_cursor", int'(out_cursor), 0);
    u0 = updates_seen;
    in_rst = 1'b0;
    sb_q.push_back(0);
    count_low(-1, 0, 0, n);
    check("init_clear_len", n, 80);
    idle(3);
    check("init_updates", updates_seen - u0, 1);
    check("init_cursor", int'(out_cursor), 0);
    sweep("init");
    read_at("oob_100", 100, 8'h20);

    // Back-to-back 'A','B'
    u0 = updates_seen;
    send_char(8'h41);
    send_char(8'h42);
    idle(3);
    check("ab_addr0", int'(mem_m[0]), 8'h41);
    read_at("ab_rd0", 0, 8'h41);
    read_at("ab_rd1", 1, 8'h42);
    check("ab_cursor", int'(out_cursor), 2);
    check("ab_updates", updates_seen - u0, 2);

    // Table: printable runs and line control
    for (int unsigned i = 0; i < 14; i++) begin
      for (int r = 0; r < tbl[i].reps; r++) send_char(tbl[i].ch);
      idle(2);
      check($sformatf("tbl%0d_cursor", i), int'(out_cursor), tbl[i].exp_cur);
      sweep($sformatf("tbl%0d", i));
    end

    // Wrap: 81 chars streamed from cursor 0
    c0 = cycles;
    for (int i = 0; i < 81; i++) send_char(8'(8'h41 + (i % 26)));
    check("wrap_cycles", cycles - c0, 81);
    idle(2);
    read_at("wrap_addr0", 0, 8'h43);
    read_at("wrap_addr1", 1, 8'h42);
    read_at("wrap_addr79", 79, 8'h42);
    read_at("oob_127", 127, 8'h20);
    check("wrap_cursor", int'(out_cursor), 1);
    sweep("wrap");

    // FF with valid held and 'Z' queued behind it
    snap = mem_m;
    send_char(8'h0C);
    in_char = 8'h5A;
    count_low(41, 60, int'(snap[60]), n);
    check("ff_clear_len", n, 80);
    send_char(8'h5A);
    idle(3);
    read_at("ff_z_addr0", 0, 8'h5A);
    check("ff_cursor", int'(out_cursor), 1);
    sweep("ff");

    // Reset in the middle of a clear
    for (int i = 0; i < 55; i++) send_char(8'(8'h61 + (i % 26)));
    idle(1);
    snap = mem_m;
    send_char(8'h0C);
    in_char_valid = 1'b0;
    repeat (39) @(posedge in_clk);
    #1;
    in_rst = 1'b1;
    sb_q.delete();
    model_clear();
    #1;
    check("mid_rst_ready", int'(out_char_ready), 0);
    check("mid_rst_update", int'(out_update), 0);
    check("mid_rst_cursor", int'(out_cursor), 0);
    repeat (3) @(posedge in_clk);
    #1;
    in_rst = 1'b0;
    sb_q.push_back(0);
    count_low(11, 50, int'(snap[50]), n);
    check("mid_rst_clear_len", n, 80);
    idle(3);
    check("mid_rst_cursor_after", int'(out_cursor), 0);
    sweep("mid_rst");

    check("sb_drain", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
